m68k_bus_target: RTL and testbench

- 68000 asynchronous bus responder inside the FPGA; the counterpart to the FPGA bus-master sequencer.
- When the CPU owns the bus, it decodes a parameterised address window, converts AS/UDS/LDS/RW cycles into single-cycle register strobes on a local register port, and drives DTACK (or BERR on timeout).
- Local peripherals (FTDI status, SPI, RTC shims) hang off the register port.

---
 rtl/m68k_bus_pkg.sv | 18 +
 rtl/sync2.sv | 23 ++
 rtl/m68k_bus_target.sv | 156 +++++++++++++++
 tb/tb_m68k_bus_target.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000 bus target and the FPGA bus-master sequencer.
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STROBE = 3'd1,
        WAIT   = 3'd2,
        ACK    = 3'd3,
        ERR    = 3'd4,
        REL    = 3'd5
    } bus_state_t;

    // FTDI status window as a byte address; bit 0 never appears on the 68000 bus.
    localparam logic [23:0] FTDI_STATUS_BASE = 24'h780000;

    localparam int TIMER_W = 16;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous control line, with a selectable reset level.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic cpuclk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge cpuclk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/m68k_bus_target.sv
// 68000 bus responder: decodes an address window, turns CPU cycles into single-cycle
// register strobes and answers with DTACK, or BERR when the register port never acknowledges.
module m68k_bus_target
    import m68k_bus_pkg::*;
#(
    parameter logic [23:0] BASE    = FTDI_STATUS_BASE,
    parameter int          AWIDTH  = 4,
    parameter int          TIMEOUT = 255
) (
    input  logic              cpuclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              as_n,
    input  logic              uds_n,
    input  logic              lds_n,
    input  logic              rw,
    input  logic [23:1]       addr,
    input  logic [15:0]       data_in,
    output logic [15:0]       data_out,
    output logic              data_oe,
    output logic              dtack_n,
    output logic              berr_n,
    output logic [AWIDTH-1:0] reg_addr,
    output logic [1:0]        reg_be,
    output logic [15:0]       reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [15:0]       reg_rdata,
    input  logic              reg_ack
);

    localparam logic [TIMER_W-1:0] TIMEOUT_CNT = TIMER_W'(TIMEOUT);

    bus_state_t         state;
    bus_state_t         next_state;
    logic               as_s;
    logic               uds_s;
    logic               lds_s;
    logic               sel;
    logic               start;
    logic               rw_q;
    logic [TIMER_W-1:0] cnt;
    logic [TIMER_W-1:0] cnt_inc;

    sync2 #(.RESET_VAL(1'b1)) u_sync_as (
        .cpuclk (cpuclk),
        .rst_n  (rst_n),
        .d      (as_n),
        .q      (as_s)
    );

    sync2 #(.RESET_VAL(1'b1)) u_sync_uds (
        .cpuclk (cpuclk),
        .rst_n  (rst_n),
        .d      (uds_n),
        .q      (uds_s)
    );

    sync2 #(.RESET_VAL(1'b1)) u_sync_lds (
        .cpuclk (cpuclk),
        .rst_n  (rst_n),
        .d      (lds_n),
        .q      (lds_s)
    );

    // addr is read raw: the CPU holds it stable for as long as the strobes are low.
    assign sel     = enable && (addr[23:AWIDTH+1] == BASE[23:AWIDTH+1]);
    assign start   = !as_s && sel && (!uds_s || !lds_s);
    assign cnt_inc = (cnt == '1) ? cnt : cnt + TIMER_W'(1);

    assign reg_wr  = (state == STROBE) && !rw_q;
    assign reg_rd  = (state == STROBE) && rw_q;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = STROBE;
                end
            end
            STROBE: begin
                next_state = reg_ack ? ACK : WAIT;
            end
            WAIT: begin
                if (reg_ack) begin
                    next_state = ACK;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    next_state = ERR;
                end else if (as_s) begin
                    next_state = IDLE;
                end
            end
            ACK, ERR: begin
                if (as_s) begin
                    next_state = REL;
                end
            end
            REL: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (!enable) begin
            next_state = IDLE;
        end
    end

    // DTACK and the data driver are withheld the moment the synced AS is seen high,
    // so the bus is released three clocks after the CPU ends the cycle.
    always_ff @(posedge cpuclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rw_q      <= 1'b0;
            reg_addr  <= '0;
            reg_be    <= '0;
            reg_wdata <= '0;
            data_out  <= '0;
            dtack_n   <= 1'b1;
            berr_n    <= 1'b1;
            data_oe   <= 1'b0;
        end else begin
            state   <= next_state;
            dtack_n <= !(enable && (state == ACK) && !as_s);
            data_oe <= enable && (state == ACK) && !as_s && rw_q;
            berr_n  <= !(next_state == ERR);
            if (!enable) begin
                cnt       <= '0;
                rw_q      <= 1'b0;
                reg_addr  <= '0;
                reg_be    <= '0;
                reg_wdata <= '0;
                data_out  <= '0;
            end else begin
                if ((state == IDLE) && start) begin
                    reg_addr  <= addr[AWIDTH:1];
                    reg_be    <= {!uds_s, !lds_s};
                    reg_wdata <= data_in;
                    rw_q      <= rw;
                end
                if (state == STROBE) begin
                    cnt <= '0;
                end else if (state == WAIT) begin
                    cnt <= cnt_inc;
                end
                if (rw_q && reg_ack && ((state == STROBE) || (state == WAIT))) begin
                    data_out <= reg_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_m68k_bus_target.sv
// Scoreboard bench for m68k_bus_target: CPU cycles push expected bus events, a monitor
// pops and compares them as the DUT produces strobes and DTACK/BERR/OE edges.
module tb_m68k_bus_target;

    typedef enum int {
        EV_RD, EV_WR, EV_DTACK_LO, EV_DTACK_HI, EV_OE_HI, EV_OE_LO, EV_BERR_LO, EV_BERR_HI
    } ev_kind_t;

    typedef struct {
        ev_kind_t    kind;
        int          cyc;
        logic [31:0] payload;
    } exp_t;

    logic        cpuclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        as_n = 1'b1;
    logic        uds_n = 1'b1;
    logic        lds_n = 1'b1;
    logic        rw = 1'b1;
    logic [23:1] addr = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        data_oe;
    logic        dtack_n;
    logic        berr_n;
    logic [3:0]  reg_addr;
    logic [1:0]  reg_be;
    logic [15:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [15:0] reg_rdata = 16'h0BAD;
    logic        reg_ack = 1'b0;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          t_start = 0;
    int          t_end = 0;
    int          ack_delay = 0;
    int          ack_timer = -1;
    logic [15:0] rdata_val = '0;
    exp_t        sb[$];
    logic        prev_dtack = 1'b1;
    logic        prev_berr = 1'b1;
    logic        prev_oe = 1'b0;

    m68k_bus_target #(
        .BASE    (24'h780000),
        .AWIDTH  (4),
        .TIMEOUT (8)
    ) dut (
        .cpuclk    (cpuclk),
        .rst_n     (rst_n),
        .enable    (enable),
        .as_n      (as_n),
        .uds_n     (uds_n),
        .lds_n     (lds_n),
        .rw        (rw),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .dtack_n   (dtack_n),
        .berr_n    (berr_n),
        .reg_addr  (reg_addr),
        .reg_be    (reg_be),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack)
    );

    always #5 cpuclk = ~cpuclk;

    always @(posedge cpuclk) cyc++;

    function automatic logic [63:0] out_vec();
        return 64'({dtack_n, berr_n, data_oe, reg_wr, reg_rd, reg_be, reg_addr, data_out, reg_wdata});
    endfunction

    function automatic logic [63:0] rst_vec();
        return 64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 16'h0000});
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic push_exp(input ev_kind_t k, input int c, input logic [31:0] p);
        exp_t e;
        e.kind    = k;
        e.cyc     = c;
        e.payload = p;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observed_payload(input ev_kind_t k);
        case (k)
            EV_RD:    return 32'({reg_addr, reg_be});
            EV_WR:    return 32'({reg_addr, reg_be, reg_wdata});
            EV_OE_HI: return 32'(data_out);
            default:  return 32'h0;
        endcase
    endfunction

    task automatic observe(input ev_kind_t k);
        exp_t  e;
        string nm;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_%s at cycle %0d: got event, required none", k.name(), cyc);
        end else begin
            e  = sb.pop_front();
            nm = {"kind_", e.kind.name()};
            check_output(nm, 64'(k), 64'(e.kind));
            nm = {"cycle_", e.kind.name()};
            check_output(nm, 64'(cyc), 64'(e.cyc));
            if ((k == e.kind) && (k == EV_RD || k == EV_WR || k == EV_OE_HI)) begin
                nm = {"data_", k.name()};
                check_output(nm, 64'(observed_payload(k)), 64'(e.payload));
            end
        end
    endtask

    // Register-port peripheral: acknowledges each strobe after ack_delay clocks (-1 = never).
    always @(negedge cpuclk) begin
        reg_ack   = 1'b0;
        reg_rdata = 16'h0BAD;
        if (ack_timer > 0) begin
            ack_timer--;
            if (ack_timer == 0) begin
                reg_ack   = 1'b1;
                reg_rdata = rdata_val;
                ack_timer = -1;
            end
        end
        if ((reg_rd || reg_wr) && ack_delay >= 0) begin
            if (ack_delay == 0) begin
                reg_ack   = 1'b1;
                reg_rdata = rdata_val;
            end else begin
                ack_timer = ack_delay;
            end
        end
    end

    // Monitor: every strobe and every DTACK/OE/BERR edge must match the head of the scoreboard.
    always @(negedge cpuclk) begin
        if (!rst_n) begin
            prev_dtack = dtack_n;
            prev_berr  = berr_n;
            prev_oe    = data_oe;
        end else begin
            if (reg_rd) observe(EV_RD);
            if (reg_wr) observe(EV_WR);
            if (prev_dtack && !dtack_n) observe(EV_DTACK_LO);
            if (!prev_dtack && dtack_n) observe(EV_DTACK_HI);
            if (!prev_oe && data_oe) observe(EV_OE_HI);
            if (prev_oe && !data_oe) observe(EV_OE_LO);
            if (prev_berr && !berr_n) observe(EV_BERR_LO);
            if (!prev_berr && berr_n) observe(EV_BERR_HI);
            prev_dtack = dtack_n;
            prev_berr  = berr_n;
            prev_oe    = data_oe;
        end
    end

    task automatic cpu_begin(input logic [23:0] byte_addr, input logic read,
                             input logic udsn, input logic ldsn, input logic [15:0] wd);
        @(negedge cpuclk);
        addr    = byte_addr[23:1];
        rw      = read;
        data_in = wd;
        as_n    = 1'b0;
        uds_n   = udsn;
        lds_n   = ldsn;
        t_start = cyc;
    endtask

    task automatic cpu_end();
        @(negedge cpuclk);
        as_n  = 1'b1;
        uds_n = 1'b1;
        lds_n = 1'b1;
        t_end = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge cpuclk);
    endtask

    task automatic apply_stimulus();
        $display("[TB] word read, zero-wait ack");
        ack_delay = 0;
        rdata_val = 16'hA55A;
        cpu_begin(24'h780002, 1'b1, 1'b0, 1'b0, 16'h0000);
        push_exp(EV_RD, t_start + 3, 32'({4'h1, 2'b11}));
        push_exp(EV_DTACK_LO, t_start + 5, 32'h0);
        push_exp(EV_OE_HI, t_start + 5, 32'hA55A);
        idle(7);
        cpu_end();
        push_exp(EV_DTACK_HI, t_end + 3, 32'h0);
        push_exp(EV_OE_LO, t_end + 3, 32'h0);
        idle(6);

        $display("[TB] lower-byte write, ack three clocks late");
        ack_delay = 3;
        cpu_begin(24'h780004, 1'b0, 1'b1, 1'b0, 16'h00C3);
        push_exp(EV_WR, t_start + 3, 32'({4'h2, 2'b01, 16'h00C3}));
        push_exp(EV_DTACK_LO, t_start + 8, 32'h0);
        idle(10);
        cpu_end();
        push_exp(EV_DTACK_HI, t_end + 3, 32'h0);
        idle(6);

        $display("[TB] access outside the window");
        ack_delay = 0;
        cpu_begin(24'h000100, 1'b1, 1'b0, 1'b0, 16'h0000);
        idle(8);
        check_output("unsel_bus", 64'({dtack_n, berr_n}), 64'(2'b11));
        cpu_end();
        idle(6);

        $display("[TB] no ack, bus error after timeout");
        ack_delay = -1;
        cpu_begin(24'h780006, 1'b1, 1'b0, 1'b0, 16'h0000);
        push_exp(EV_RD, t_start + 3, 32'({4'h3, 2'b11}));
        push_exp(EV_BERR_LO, t_start + 12, 32'h0);
        idle(15);
        check_output("tmo_no_dtack", 64'(dtack_n), 64'(1'b1));
        cpu_end();
        push_exp(EV_BERR_HI, t_end + 3, 32'h0);
        idle(6);

        $display("[TB] CPU aborts in WAIT, late ack ignored");
        ack_delay = 6;
        rdata_val = 16'h1234;
        cpu_begin(24'h780008, 1'b1, 1'b0, 1'b0, 16'h0000);
        push_exp(EV_RD, t_start + 3, 32'({4'h4, 2'b11}));
        idle(3);
        cpu_end();
        idle(10);
        check_output("abort_no_dtack", 64'(dtack_n), 64'(1'b1));
        ack_delay = 0;
        rdata_val = 16'h0F0F;
        cpu_begin(24'h78000A, 1'b1, 1'b0, 1'b0, 16'h0000);
        push_exp(EV_RD, t_start + 3, 32'({4'h5, 2'b11}));
        push_exp(EV_DTACK_LO, t_start + 5, 32'h0);
        push_exp(EV_OE_HI, t_start + 5, 32'h0F0F);
        idle(7);
        cpu_end();
        push_exp(EV_DTACK_HI, t_end + 3, 32'h0);
        push_exp(EV_OE_LO, t_end + 3, 32'h0);
        idle(6);

        $display("[TB] enable drops during a selected read");
        cpu_begin(24'h78000C, 1'b1, 1'b0, 1'b0, 16'h0000);
        @(negedge cpuclk);
        enable = 1'b0;
        idle(6);
        check_output("en_off_outputs", out_vec(), rst_vec());
        cpu_end();
        idle(3);
        enable = 1'b1;
        idle(4);

        $display("[TB] reset pulsed while in ACK");
        rdata_val = 16'hBEEF;
        cpu_begin(24'h78000E, 1'b1, 1'b0, 1'b0, 16'h0000);
        push_exp(EV_RD, t_start + 3, 32'({4'h7, 2'b11}));
        push_exp(EV_DTACK_LO, t_start + 5, 32'h0);
        push_exp(EV_OE_HI, t_start + 5, 32'hBEEF);
        idle(7);
        @(posedge cpuclk);
        #2;
        rst_n = 1'b0;
        as_n  = 1'b1;
        uds_n = 1'b1;
        lds_n = 1'b1;
        #1;
        check_output("rst_mid_ack", out_vec(), rst_vec());
        @(negedge cpuclk);
        #2;
        rst_n = 1'b1;
        idle(6);
    endtask

    initial begin
        idle(3);
        check_output("reset_state", out_vec(), rst_vec());
        rst_n = 1'b1;
        idle(3);
        apply_stimulus();
        check_output("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, required finish");
        $fatal(1);
    end

endmodule
